// File: rtl/matrix_dispatch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | matrix_dispatch_unit: queued matrix-command dispatcher, round-robin issue  |
// | to NUM_ENGINES engines with per-engine FSM/watchdog and tagged completions |
// | Optional perf counters: DISPATCH_PERF_CNT_EN             Revision: 1.0     |
// +----------------------------------------------------------------------------+
module matrix_dispatch_unit #(
  parameter int NUM_ENGINES    = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int ADDR_W         = 32,
  parameter int DIM_W          = 32,
  parameter int OP_W           = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [OP_W-1:0]                   cmd_op,
  input  logic [ADDR_W-1:0]                 cmd_src1,
  input  logic [ADDR_W-1:0]                 cmd_src2,
  input  logic [ADDR_W-1:0]                 cmd_dest,
  input  logic [DIM_W-1:0]                  cmd_dim,
  input  logic [TAG_W-1:0]                  cmd_tag,
  output logic [NUM_ENGINES-1:0]            eng_start,
  output logic [NUM_ENGINES*OP_W-1:0]       eng_op,
  output logic [NUM_ENGINES*ADDR_W-1:0]     eng_src1,
  output logic [NUM_ENGINES*ADDR_W-1:0]     eng_src2,
  output logic [NUM_ENGINES*ADDR_W-1:0]     eng_dest,
  output logic [NUM_ENGINES*DIM_W-1:0]      eng_dim,
  input  logic [NUM_ENGINES-1:0]            eng_busy,
  input  logic [NUM_ENGINES-1:0]            eng_done,
  input  logic [NUM_ENGINES-1:0]            eng_error,
  output logic                              cpl_valid,
  output logic [TAG_W-1:0]                  cpl_tag,
  output logic [$clog2(NUM_ENGINES):0]      cpl_engine,
  output logic                              cpl_error,
  output logic                              cpl_timeout,
  output logic [$clog2(QUEUE_DEPTH):0]      queue_count,
`ifdef DISPATCH_PERF_CNT_EN
  input  logic                              perf_clr,
  output logic [31:0]                       perf_issued,
  output logic [31:0]                       perf_errors,
  output logic [31:0]                       perf_stall,
`endif
  output logic                              idle
);

  localparam int EW   = $clog2(NUM_ENGINES) + 1;
  localparam int QW   = $clog2(QUEUE_DEPTH);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  logic [OP_W-1:0]   q_op   [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_src1 [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_src2 [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_dest [QUEUE_DEPTH];
  logic [DIM_W-1:0]  q_dim  [QUEUE_DEPTH];
  logic [TAG_W-1:0]  q_tag  [QUEUE_DEPTH];

  logic [QW-1:0] r_wptr, r_rptr;
  logic [QW:0]   r_count, w_count_nxt;
  logic          w_full, w_empty, w_push, w_issue;
  logic [EW-1:0] r_rr_ptr, w_sel, w_sel_hi, w_sel_lo, w_cpl_sel;
  logic          w_hi_found, r_idle;
  logic [NUM_ENGINES-1:0]       w_is_idle, w_is_report, w_nxt_idle, w_err_all, w_to_all;
  logic [NUM_ENGINES*TAG_W-1:0] w_tag_all;
  logic          w_unused_busy;

  assign w_unused_busy = &{1'b0, eng_busy};

  assign w_full      = (r_count == (QW+1)'(QUEUE_DEPTH));
  assign w_empty     = (r_count == '0);
  assign cmd_ready   = !w_full;
  assign w_push      = cmd_valid && !w_full;
  assign w_issue     = !w_empty && (|w_is_idle);
  assign w_count_nxt = r_count + {{QW{1'b0}}, w_push} - {{QW{1'b0}}, w_issue};
  assign queue_count = r_count;
  assign idle        = r_idle;

  always_ff @(posedge clk) begin
    if (w_push) begin
      q_op[r_wptr]   <= cmd_op;
      q_src1[r_wptr] <= cmd_src1;
      q_src2[r_wptr] <= cmd_src2;
      q_dest[r_wptr] <= cmd_dest;
      q_dim[r_wptr]  <= cmd_dim;
      q_tag[r_wptr]  <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
      r_idle   <= 1'b1;
    end else begin
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_issue) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      if (w_issue) r_rr_ptr <= (w_sel == EW'(NUM_ENGINES - 1)) ? '0 : w_sel + 1'b1;
      r_idle  <= (w_count_nxt == '0) && (&w_nxt_idle);
    end
  end

  // Lowest idle index at/after rr_ptr, else lowest idle index overall (wrap).
  always_comb begin
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    w_hi_found = 1'b0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (w_is_idle[i]) begin
        w_sel_lo = EW'(i);
        if (EW'(i) >= r_rr_ptr) begin
          w_sel_hi   = EW'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_sel = w_hi_found ? w_sel_hi : w_sel_lo;
  end

  always_comb begin
    w_cpl_sel   = '0;
    cpl_tag     = '0;
    cpl_error   = 1'b0;
    cpl_timeout = 1'b0;
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (w_is_report[i]) begin
        w_cpl_sel   = EW'(i);
        cpl_tag     = w_tag_all[i*TAG_W +: TAG_W];
        cpl_error   = w_err_all[i];
        cpl_timeout = w_to_all[i];
      end
    end
  end

  assign cpl_valid  = |w_is_report;
  assign cpl_engine = w_cpl_sel;

  for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_eng
    logic [1:0]        r_state, w_state_nxt;
    logic [OP_W-1:0]   r_op;
    logic [ADDR_W-1:0] r_src1, r_src2, r_dest;
    logic [DIM_W-1:0]  r_dim;
    logic [TAG_W-1:0]  r_tag;
    logic              r_err, r_to;
    logic [WD_W-1:0]   r_wd;
    logic              w_start, w_emit, w_expire;

    assign w_start  = w_issue && (w_sel == EW'(i));
    assign w_emit   = (r_state == S_REPORT) && (w_cpl_sel == EW'(i));
    assign w_expire = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        S_IDLE:   if (w_start) w_state_nxt = S_RUN;
        S_RUN:    if (eng_done[i] || eng_error[i] || w_expire) w_state_nxt = S_REPORT;
        S_REPORT: if (w_emit) w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_op    <= '0;
        r_src1  <= '0;
        r_src2  <= '0;
        r_dest  <= '0;
        r_dim   <= '0;
        r_tag   <= '0;
        r_err   <= 1'b0;
        r_to    <= 1'b0;
        r_wd    <= '0;
      end else begin
        r_state <= w_state_nxt;
        if (w_start) begin
          r_op   <= q_op[r_rptr];
          r_src1 <= q_src1[r_rptr];
          r_src2 <= q_src2[r_rptr];
          r_dest <= q_dest[r_rptr];
          r_dim  <= q_dim[r_rptr];
          r_tag  <= q_tag[r_rptr];
          r_err  <= 1'b0;
          r_to   <= 1'b0;
          r_wd   <= '0;
        end else if (r_state == S_RUN) begin
          if (r_wd != WD_W'(TIMEOUT_CYCLES)) r_wd <= r_wd + 1'b1;
          if (eng_error[i] || w_expire) r_err <= 1'b1;
          if (w_expire) r_to <= 1'b1;
        end
      end
    end

    // Operands are shown from the queue head during the start cycle, then held.
    assign eng_start[i]                   = w_start;
    assign eng_op[i*OP_W +: OP_W]         = w_start ? q_op[r_rptr]   : r_op;
    assign eng_src1[i*ADDR_W +: ADDR_W]   = w_start ? q_src1[r_rptr] : r_src1;
    assign eng_src2[i*ADDR_W +: ADDR_W]   = w_start ? q_src2[r_rptr] : r_src2;
    assign eng_dest[i*ADDR_W +: ADDR_W]   = w_start ? q_dest[r_rptr] : r_dest;
    assign eng_dim[i*DIM_W +: DIM_W]      = w_start ? q_dim[r_rptr]  : r_dim;
    assign w_is_idle[i]                   = (r_state == S_IDLE);
    assign w_is_report[i]                 = (r_state == S_REPORT);
    assign w_nxt_idle[i]                  = (w_state_nxt == S_IDLE);
    assign w_err_all[i]                   = r_err;
    assign w_to_all[i]                    = r_to;
    assign w_tag_all[i*TAG_W +: TAG_W]    = r_tag;
  end

`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_errors <= '0;
      perf_stall  <= '0;
    end else if (perf_clr) begin
      perf_issued <= '0;
      perf_errors <= '0;
      perf_stall  <= '0;
    end else begin
      if (w_issue)                   perf_issued <= perf_issued + 32'd1;
      if (cpl_valid && cpl_error)    perf_errors <= perf_errors + 32'd1;
      if (!w_empty && !(|w_is_idle)) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_dispatch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_matrix_dispatch_unit: directed bench for matrix_dispatch_unit           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_matrix_dispatch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op, cmd_tag;
  logic [31:0] cmd_src1, cmd_src2, cmd_dest, cmd_dim;
  logic [1:0]  eng_start, eng_busy, eng_done, eng_error;
  logic [7:0]  eng_op;
  logic [63:0] eng_src1, eng_src2, eng_dest, eng_dim;
  logic        cpl_valid, cpl_error, cpl_timeout, idle;
  logic [3:0]  cpl_tag;
  logic [1:0]  cpl_engine;
  logic [2:0]  queue_count;

  int n_chk  = 0;
  int n_pass = 0;

  matrix_dispatch_unit #(
    .NUM_ENGINES(2), .QUEUE_DEPTH(4), .ADDR_W(32), .DIM_W(32),
    .OP_W(4), .TAG_W(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dest(cmd_dest),
    .cmd_dim(cmd_dim), .cmd_tag(cmd_tag),
    .eng_start(eng_start), .eng_op(eng_op), .eng_src1(eng_src1),
    .eng_src2(eng_src2), .eng_dest(eng_dest), .eng_dim(eng_dim),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_error(eng_error),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_engine(cpl_engine),
    .cpl_error(cpl_error), .cpl_timeout(cpl_timeout),
    .queue_count(queue_count), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_tag   = tag;
    cmd_src1  = 32'h1000 + 32'(tag);
    cmd_src2  = 32'h2000 + 32'(tag);
    cmd_dest  = 32'h3000 + 32'(tag);
    cmd_dim   = {16'd4, 12'd0, tag};
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    eng_done  = '0;
    eng_error = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_tag = '0;
    cmd_src1 = '0; cmd_src2 = '0; cmd_dest = '0; cmd_dim = '0;
    eng_busy = '0; eng_done = '0; eng_error = '0;
    cyc(); cyc();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_start", 64'(eng_start), 64'd0);
    chk("rst_cpl", 64'(cpl_valid), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    rst_n = 1'b1;

    // single command
    push(4'd3, 4'd5);
    cyc();
    cmd_valid = 1'b0;
    chk("s_start", 64'(eng_start), 64'b01);
    chk("s_op", 64'(eng_op[3:0]), 64'd3);
    chk("s_src1", 64'(eng_src1[31:0]), 64'h1005);
    chk("s_src2", 64'(eng_src2[31:0]), 64'h2005);
    chk("s_dest", 64'(eng_dest[31:0]), 64'h3005);
    chk("s_dim", 64'(eng_dim[31:0]), 64'h0004_0005);
    chk("s_count1", 64'(queue_count), 64'd1);
    chk("s_busy_idle", 64'(idle), 64'd0);
    cyc();
    chk("s_start_once", 64'(eng_start), 64'd0);
    chk("s_op_held", 64'(eng_op[3:0]), 64'd3);
    chk("s_count0", 64'(queue_count), 64'd0);
    for (int k = 3; k <= 10; k++) cyc();
    eng_done = 2'b01;
    chk("s_no_early_cpl", 64'(cpl_valid), 64'd0);
    cyc();
    eng_done = 2'b00;
    chk("s_cpl", 64'(cpl_valid), 64'd1);
    chk("s_cpl_tag", 64'(cpl_tag), 64'd5);
    chk("s_cpl_eng", 64'(cpl_engine), 64'd0);
    chk("s_cpl_err", 64'(cpl_error), 64'd0);
    chk("s_cpl_to", 64'(cpl_timeout), 64'd0);
    cyc();
    chk("s_cpl_once", 64'(cpl_valid), 64'd0);
    chk("s_idle_after", 64'(idle), 64'd1);

    // round-robin
    do_reset();
    push(4'd5, 4'd1);
    cyc();
    push(4'd6, 4'd2);
    chk("rr_first", 64'(eng_start), 64'b01);
    cyc();
    push(4'd9, 4'd3);
    chk("rr_second", 64'(eng_start), 64'b10);
    chk("rr_second_op", 64'(eng_op[7:4]), 64'd6);
    cyc();
    cmd_valid = 1'b0;
    chk("rr_third_wait", 64'(eng_start), 64'd0);
    chk("rr_count1", 64'(queue_count), 64'd1);
    cyc();
    eng_done = 2'b01;
    cyc();
    eng_done = 2'b00;
    chk("rr_cpl_tag", 64'(cpl_tag), 64'd1);
    chk("rr_no_reissue", 64'(eng_start), 64'd0);
    cyc();
    chk("rr_third_issue", 64'(eng_start), 64'b01);
    chk("rr_third_op", 64'(eng_op[3:0]), 64'd9);
    chk("rr_e1_held", 64'(eng_op[7:4]), 64'd6);
    cyc();
    chk("rr_count0", 64'(queue_count), 64'd0);

    // queue full
    do_reset();
    for (int k = 0; k < 6; k++) begin
      push(4'(k + 1), 4'(k));
      cyc();
    end
    push(4'd7, 4'd6);
    chk("qf_count", 64'(queue_count), 64'd4);
    chk("qf_ready", 64'(cmd_ready), 64'd0);
    cyc();
    eng_done = 2'b01;
    chk("qf_still_full", 64'(queue_count), 64'd4);
    cyc();
    eng_done = 2'b00;
    chk("qf_cpl_tag", 64'(cpl_tag), 64'd0);
    chk("qf_refuse", 64'(queue_count), 64'd4);
    cyc();
    chk("qf_issue", 64'(eng_start), 64'b01);
    chk("qf_issue_op", 64'(eng_op[3:0]), 64'd3);
    chk("qf_pop_no_push", 64'(cmd_ready), 64'd0);
    cyc();
    chk("qf_ready_again", 64'(cmd_ready), 64'd1);
    chk("qf_count3", 64'(queue_count), 64'd3);
    cyc();
    cmd_valid = 1'b0;
    chk("qf_seventh_in", 64'(queue_count), 64'd4);

    // simultaneous completion
    do_reset();
    push(4'd1, 4'd7);
    cyc();
    push(4'd2, 4'd8);
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cyc();
    eng_done  = 2'b01;
    eng_error = 2'b10;
    cyc();
    eng_done  = 2'b00;
    eng_error = 2'b00;
    chk("sc_first_v", 64'(cpl_valid), 64'd1);
    chk("sc_first_eng", 64'(cpl_engine), 64'd0);
    chk("sc_first_tag", 64'(cpl_tag), 64'd7);
    chk("sc_first_err", 64'(cpl_error), 64'd0);
    cyc();
    chk("sc_second_v", 64'(cpl_valid), 64'd1);
    chk("sc_second_eng", 64'(cpl_engine), 64'd1);
    chk("sc_second_tag", 64'(cpl_tag), 64'd8);
    chk("sc_second_err", 64'(cpl_error), 64'd1);
    chk("sc_second_to", 64'(cpl_timeout), 64'd0);
    cyc();
    chk("sc_done", 64'(cpl_valid), 64'd0);
    chk("sc_idle", 64'(idle), 64'd1);

    // watchdog timeout
    do_reset();
    push(4'd4, 4'd9);
    cyc();
    cmd_valid = 1'b0;
    chk("to_start", 64'(eng_start), 64'b01);
    for (int k = 2; k <= 17; k++) cyc();
    chk("to_not_yet", 64'(cpl_valid), 64'd0);
    cyc();
    chk("to_cpl", 64'(cpl_valid), 64'd1);
    chk("to_tag", 64'(cpl_tag), 64'd9);
    chk("to_err", 64'(cpl_error), 64'd1);
    chk("to_flag", 64'(cpl_timeout), 64'd1);
    cyc();
    eng_done = 2'b01;
    chk("to_idle", 64'(idle), 64'd1);
    cyc();
    eng_done = 2'b00;
    chk("to_late_done", 64'(cpl_valid), 64'd0);

    // reset mid-run
    do_reset();
    for (int k = 0; k < 5; k++) begin
      push(4'(k + 2), 4'(k + 10));
      cyc();
    end
    cmd_valid = 1'b0;
    chk("mr_count3", 64'(queue_count), 64'd3);
    chk("mr_busy", 64'(idle), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_count", 64'(queue_count), 64'd0);
    chk("mr_ready", 64'(cmd_ready), 64'd1);
    chk("mr_idle", 64'(idle), 64'd1);
    chk("mr_op", 64'(eng_op), 64'd0);
    chk("mr_src1", 64'(eng_src1), 64'd0);
    chk("mr_cpl", 64'(cpl_valid), 64'd0);
    cyc();
    rst_n = 1'b1;
    eng_done = 2'b11;
    cyc();
    eng_done = 2'b00;
    for (int k = 0; k < 3; k++) begin
      chk("mr_no_cpl", 64'(cpl_valid), 64'd0);
      chk("mr_no_start", 64'(eng_start), 64'd0);
      cyc();
    end
    chk("mr_idle_end", 64'(idle), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
